// File: rtl/cic_pkg.sv
// Shared sizing and saturation helpers for the CIC interpolator.
package cic_pkg;

    function automatic int rate_w(input int max_rate);
        return $clog2(max_rate) + 1;
    endfunction

    function automatic int acc_w(input int bit_width, input int stages, input int max_rate);
        return bit_width + stages * $clog2(max_rate);
    endfunction

    // Clamp a signed value to the range of a bit_width-bit two's-complement number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int bit_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bit_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bit_width - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/cic_integ_stage.sv
// One CIC integrator: registered wrap-around accumulator that advances only with en.
module cic_integ_stage #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= q + din;
    end

endmodule

// File: rtl/cic_interp_v2.sv
// CIC interpolator with runtime rate, zero-stuffer and sticky underrun flag.
// Define CIC_OUT_SAT_EN to saturate the output instead of wrapping it.
module cic_interp_v2
    import cic_pkg::*;
#(
    parameter int BIT_WIDTH       = 8,
    parameter int STAGES          = 3,
    parameter int MAX_RATE        = 16,
    parameter int OUT_SCALE_SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [rate_w(MAX_RATE)-1:0]   rate,
    input  logic signed [BIT_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [BIT_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    output logic                          underrun
);

    localparam int RATE_W = rate_w(MAX_RATE);
    localparam int ACC_W  = acc_w(BIT_WIDTH, STAGES, MAX_RATE);
    localparam int WARM_N = STAGES + 2;
    localparam int WARM_W = $clog2(WARM_N + 1);

    logic [RATE_W-1:0] phase, phase_next, r_act, r_cur, rate_clamped;
    logic              phase0;
    logic [WARM_W-1:0] warm;

    logic [STAGES-1:0][ACC_W-1:0] comb_d;
    logic [STAGES:0][ACC_W-1:0]   comb_v;
    logic [ACC_W-1:0]             stuff;
    logic [STAGES-1:0][ACC_W-1:0] integ_in, integ_q;

    logic signed [ACC_W-1:0]     shifted;
    logic signed [BIT_WIDTH-1:0] narrowed;

    always_comb begin
        if (rate == '0)                       rate_clamped = RATE_W'(1);
        else if (rate > RATE_W'(MAX_RATE))    rate_clamped = RATE_W'(MAX_RATE);
        else                                  rate_clamped = rate;
    end

    // A new rate takes effect at the phase-0 slot it is latched in.
    assign phase0     = (phase == '0);
    assign r_cur      = phase0 ? rate_clamped : r_act;
    assign phase_next = (phase == r_cur - RATE_W'(1)) ? '0 : phase + RATE_W'(1);
    assign in_ready   = enable && phase0;

    always_comb begin
        comb_v[0] = in_valid ? ACC_W'(in_data) : '0;
        for (int i = 0; i < STAGES; i++)
            comb_v[i+1] = comb_v[i] - comb_d[i];
    end

    always_comb begin
        integ_in[0] = stuff;
        for (int i = 1; i < STAGES; i++)
            integ_in[i] = integ_q[i-1];
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_integ
        cic_integ_stage #(.W(ACC_W)) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (enable),
            .din (integ_in[g]),
            .q   (integ_q[g])
        );
    end

    assign shifted = $signed(integ_q[STAGES-1]) >>> OUT_SCALE_SHIFT;

    always_comb begin
`ifdef CIC_OUT_SAT_EN
        narrowed = BIT_WIDTH'(sat(64'(shifted), BIT_WIDTH));
`else
        narrowed = shifted[BIT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= '0;
            r_act     <= RATE_W'(1);
            comb_d    <= '0;
            stuff     <= '0;
            warm      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (enable) begin
                phase <= phase_next;
                if (phase0) begin
                    r_act <= rate_clamped;
                    for (int i = 0; i < STAGES; i++)
                        comb_d[i] <= comb_v[i];
                    if (!in_valid) underrun <= 1'b1;
                end
                stuff <= phase0 ? comb_v[STAGES] : '0;
                if (warm != WARM_W'(WARM_N)) warm <= warm + WARM_W'(1);
                // out_valid marks a fresh out_data produced by this enabled edge.
                out_valid <= (warm >= WARM_W'(WARM_N - 1));
                out_data  <= narrowed;
            end
        end
    end

endmodule

// File: doc/cic_interp_v2.md
CIC_INTERP_V2 -- requirements
Module: cic_interp_v2

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, input/output sample width (signed).
REQ-002 SHALL have parameter STAGES, default 3, number of comb and integrator stages (1..6).
REQ-003 SHALL have parameter MAX_RATE, default 16, largest supported interpolation rate (>=2).
REQ-004 SHALL have parameter OUT_SCALE_SHIFT, default 0, arithmetic right shift applied before output narrowing.
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, global advance; low freezes all state.
REQ-008 SHALL have port rate, input, clog2(MAX_RATE)+1, runtime interpolation rate R.
REQ-009 SHALL have port in_data, input, BIT_WIDTH, signed input sample.
REQ-010 SHALL have port in_valid, input, 1, input sample present.
REQ-011 SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-012 SHALL have port out_data, output, BIT_WIDTH, signed interpolated sample.
REQ-013 SHALL have port out_valid, output, 1, out_data valid this cycle.
REQ-014 SHALL have port underrun, output, 1, sticky flag, set on a missed input slot.

Function
REQ-015 SHALL use internal width ACC_W = BIT_WIDTH + STAGES*clog2(MAX_RATE) for all comb/integrator registers, two's-complement wrap.
REQ-016 SHALL hold a phase counter 0..R_act-1, advancing once per cycle with enable high, wrapping to 0.
REQ-017 SHALL latch R_act from rate only when phase==0 and enable high; rate 0 -> 1, rate >MAX_RATE -> MAX_RATE.
REQ-018 SHALL drive in_ready = enable && phase==0, combinationally.
REQ-019 SHALL, at phase==0 with in_valid high, push sign-extended in_data through the comb chain (y = x - x_delayed per stage, delays updated).
REQ-020 SHALL, at phase==0 with in_valid low, push zero through the comb chain and set underrun.
REQ-021 SHALL register comb output into the zero-stuffer at phase 0; stuffer is 0 in all other phases.
REQ-022 SHALL update every integrator each enabled cycle: integ[0] += stuffer, integ[i] += integ[i-1] (registered values).
REQ-023 SHALL produce out_data registered from integ[STAGES-1] >>> OUT_SCALE_SHIFT, narrowed per REQ-030.
REQ-024 SHALL assert out_valid every enabled cycle once STAGES+2 enabled cycles have elapsed since reset; low otherwise.
REQ-025 SHALL give latency of STAGES+2 enabled cycles from sample accept to first contribution on out_data.
REQ-026 SHALL, with enable low, hold all registers, phase and out_data; out_valid low.
REQ-027 SHALL, for R_act=1, accept a sample every enabled cycle with no zero stuffing.

Reset
REQ-028 SHALL on rst clear comb delays, stuffer, integrators, phase, warm-up count, out_data, out_valid, underrun to 0 and set R_act to 1, asynchronously.
REQ-029 SHALL clear underrun only by reset; reset mid-burst discards all in-flight samples.

Configuration
REQ-030 SHALL, with CIC_OUT_SAT_EN defined, saturate shifted result to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]; without it, truncate to low BIT_WIDTH bits (wrap).

Structure
REQ-031 SHALL place ACC_W function, RATE_W constant function and saturation function in package cic_pkg.
REQ-032 SHALL instantiate sub-module cic_integ_stage (one registered accumulator with enable) STAGES times; combs inline.

Verification
REQ-033 SHALL cover impulse: BIT_WIDTH 8, STAGES 3, R 4, shift 0, single 1 then zeros -> out_data 1,3,6,10,12,12,10,6,3,1 then 0.
REQ-034 SHALL cover DC: in_data=1 every slot, R 4 -> out_data settles to 16.
REQ-035 SHALL cover saturation: in_data=127 DC, R 4 -> 127 with CIC_OUT_SAT_EN, -16 without.
REQ-036 SHALL cover underrun: in_valid low at one phase-0 slot -> underrun=1, stays 1 until rst.
REQ-037 SHALL cover rate change: rate 4->2 mid-phase -> in_ready spacing changes only after next phase 0; rate 0 -> in_ready every cycle.
REQ-038 SHALL cover enable low for 5 cycles mid-burst -> out_data held, out_valid low, output sequence resumes unaltered.
